// File: rtl/rect_renderer.sv
// rect_renderer
//   Rectangle rasteriser. A start in IDLE latches origin, size, mode and colour,
//   then one pixel coordinate is offered per cycle on a valid/ready stream in
//   raster order. Outline mode skips interior pixels of the middle rows.
//
// Ports
//   clock, resetn        : clock (rising edge), asynchronous active-low reset
//   start                : request a new rectangle (only honoured in IDLE)
//   origin_x, origin_y   : top-left corner
//   width, height        : rectangle size in pixels (0 in either = no pixels)
//   outline              : 0 = filled, 1 = border only
//   color                : pixel colour
//   out_x, out_y         : current pixel coordinate (wraps, no clipping)
//   out_color            : latched colour
//   out_valid, out_ready : pixel stream handshake
//   busy                 : high while drawing or finishing
//   done                 : one-cycle pulse after the last pixel transfer
module rect_renderer #(
  parameter int X_WIDTH     = 8,
  parameter int Y_WIDTH     = 7,
  parameter int SIZE_WIDTH  = 8,
  parameter int COLOR_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [X_WIDTH-1:0]     origin_x,
  input  logic [Y_WIDTH-1:0]     origin_y,
  input  logic [SIZE_WIDTH-1:0]  width,
  input  logic [SIZE_WIDTH-1:0]  height,
  input  logic                   outline,
  input  logic [COLOR_WIDTH-1:0] color,
  output logic [X_WIDTH-1:0]     out_x,
  output logic [Y_WIDTH-1:0]     out_y,
  output logic [COLOR_WIDTH-1:0] out_color,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t                 state_reg,   state_next;
  logic [X_WIDTH-1:0]     ox_reg,      ox_next;
  logic [Y_WIDTH-1:0]     oy_reg,      oy_next;
  logic [SIZE_WIDTH-1:0]  w_reg,       w_next;
  logic [SIZE_WIDTH-1:0]  h_reg,       h_next;
  logic                   outline_reg, outline_next;
  logic [COLOR_WIDTH-1:0] color_reg,   color_next;
  logic [SIZE_WIDTH-1:0]  dx_reg,      dx_next;
  logic [SIZE_WIDTH-1:0]  dy_reg,      dy_next;

  // Last-column / last-row limits are taken from the latched size, so the
  // full SIZE_WIDTH range of sizes works without a wider counter.
  logic [SIZE_WIDTH-1:0] w_m1, h_m1;
  assign w_m1 = w_reg - SIZE_WIDTH'(1);
  assign h_m1 = h_reg - SIZE_WIDTH'(1);

  // Coordinate sums are formed at full width and then truncated, which gives
  // the intended screen wrap-around.
  logic [X_WIDTH+SIZE_WIDTH-1:0] sum_x;
  logic [Y_WIDTH+SIZE_WIDTH-1:0] sum_y;
  assign sum_x = {{SIZE_WIDTH{1'b0}}, ox_reg} + {{X_WIDTH{1'b0}}, dx_reg};
  assign sum_y = {{SIZE_WIDTH{1'b0}}, oy_reg} + {{Y_WIDTH{1'b0}}, dy_reg};

  assign out_x     = sum_x[X_WIDTH-1:0];
  assign out_y     = sum_y[Y_WIDTH-1:0];
  assign out_color = color_reg;
  // Driven purely from state so it never depends on out_ready.
  assign out_valid = (state_reg == DRAW);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);

  always_comb begin
    state_next   = state_reg;
    ox_next      = ox_reg;
    oy_next      = oy_reg;
    w_next       = w_reg;
    h_next       = h_reg;
    outline_next = outline_reg;
    color_next   = color_reg;
    dx_next      = dx_reg;
    dy_next      = dy_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          ox_next      = origin_x;
          oy_next      = origin_y;
          w_next       = width;
          h_next       = height;
          outline_next = outline;
          color_next   = color;
          dx_next      = '0;
          dy_next      = '0;
          if (width == '0 || height == '0) state_next = DONE;
          else                             state_next = DRAW;
        end
      end
      DRAW: begin
        if (out_ready) begin
          if (dx_reg == w_m1) begin
            dx_next = '0;
            if (dy_reg == h_m1) state_next = DONE;
            else                dy_next = dy_reg + SIZE_WIDTH'(1);
          end else if (outline_reg && dx_reg == '0 &&
                       dy_reg != '0 && dy_reg != h_m1) begin
            // Jump from the left border straight to the right border.
            dx_next = w_m1;
          end else begin
            dx_next = dx_reg + SIZE_WIDTH'(1);
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      ox_reg      <= '0;
      oy_reg      <= '0;
      w_reg       <= '0;
      h_reg       <= '0;
      outline_reg <= 1'b0;
      color_reg   <= '0;
      dx_reg      <= '0;
      dy_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      ox_reg      <= ox_next;
      oy_reg      <= oy_next;
      w_reg       <= w_next;
      h_reg       <= h_next;
      outline_reg <= outline_next;
      color_reg   <= color_next;
      dx_reg      <= dx_next;
      dy_reg      <= dy_next;
    end
  end

endmodule

// File: tb/tb_rect_renderer.sv
module tb_rect_renderer;

  localparam int XW = 8;
  localparam int YW = 7;
  localparam int SW = 8;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          resetn;
  logic          start;
  logic [XW-1:0] origin_x;
  logic [YW-1:0] origin_y;
  logic [SW-1:0] width;
  logic [SW-1:0] height;
  logic          outline;
  logic [CW-1:0] color;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic [CW-1:0] out_color;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  rect_renderer #(
    .X_WIDTH(XW), .Y_WIDTH(YW), .SIZE_WIDTH(SW), .COLOR_WIDTH(CW)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start),
    .origin_x(origin_x), .origin_y(origin_y), .width(width), .height(height),
    .outline(outline), .color(color),
    .out_x(out_x), .out_y(out_y), .out_color(out_color),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives one rectangle and checks the pixel stream against a list built
  // directly from the geometric definition of a filled/outlined rectangle.
  // rmode: 0 = always ready, 1 = random ready, 2 = ready pattern 1,0,0,1,...
  task automatic run_rect(input int ox, input int oy, input int w, input int h,
                          input bit ol, input int col, input int rmode,
                          input bit poke);
    int exp_x[$];
    int exp_y[$];
    int npix;
    int cyc;
    int last_xfer;
    int vcnt;
    bit stalled;
    bit rdy;
    logic [XW-1:0] hx;
    logic [YW-1:0] hy;
    logic [CW-1:0] hc;
    bit pat[4];

    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (!ol || r == 0 || r == h - 1 || c == 0 || c == w - 1) begin
          exp_x.push_back((ox + c) % (1 << XW));
          exp_y.push_back((oy + r) % (1 << YW));
        end
    npix = exp_x.size();

    @(negedge clock);
    origin_x = XW'(ox); origin_y = YW'(oy);
    width = SW'(w); height = SW'(h);
    outline = ol; color = CW'(col);
    start = 1'b1; out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    cyc = 0; last_xfer = -100; vcnt = 0; stalled = 1'b0;
    hx = '0; hy = '0; hc = '0;

    while (!done) begin
      if (cyc > 3000) begin
        check("timeout_waiting_done", 32'(done), 32'd1);
        break;
      end
      check("out_valid_in_draw", 32'(out_valid), 32'd1);
      check("busy_in_draw", 32'(busy), 32'd1);
      if (out_valid) begin
        if (stalled) begin
          check("stall_x_stable", 32'(out_x), 32'(hx));
          check("stall_y_stable", 32'(out_y), 32'(hy));
          check("stall_color_stable", 32'(out_color), 32'(hc));
        end
        case (rmode)
          0: rdy = 1'b1;
          1: rdy = ($urandom_range(0, 2) != 0);
          default: rdy = pat[vcnt % 4];
        endcase
        vcnt++;
        out_ready = rdy;
        if (rdy) begin
          if (exp_x.size() == 0) begin
            check("extra_pixel", 32'(out_valid), 32'd0);
          end else begin
            check("pixel_x", 32'(out_x), 32'(exp_x.pop_front()));
            check("pixel_y", 32'(out_y), 32'(exp_y.pop_front()));
            check("pixel_color", 32'(out_color), 32'(col));
          end
          last_xfer = cyc;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hx = out_x; hy = out_y; hc = out_color;
        end
      end
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        origin_x = XW'($urandom); origin_y = YW'($urandom);
        width = SW'($urandom); height = SW'($urandom);
        outline = 1'($urandom); color = CW'($urandom);
      end
      @(negedge clock);
      cyc++;
    end

    check("pixels_remaining", 32'(exp_x.size()), 32'd0);
    check("valid_low_in_done", 32'(out_valid), 32'd0);
    check("busy_in_done", 32'(busy), 32'd1);
    if (npix > 0) check("done_after_last", 32'(cyc - last_xfer), 32'd1);
    else          check("zero_size_done", 32'(cyc), 32'd0);
    if (rmode == 0) check("throughput", 32'(cyc), 32'(npix));
    start = poke;  // a start during DONE must be ignored
    out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_valid", 32'(out_valid), 32'd0);
    $display("rect ox=%0d oy=%0d w=%0d h=%0d outline=%0d color=%0d mode=%0d pixels=%0d cycles=%0d",
             ox, oy, w, h, ol, col, rmode, npix, cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, 32'(out_x), 32'd0);
    check({tag, "_y"}, 32'(out_y), 32'd0);
    check({tag, "_color"}, 32'(out_color), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; out_ready = 1'b0;
    origin_x = '0; origin_y = '0; width = '0; height = '0;
    outline = 1'b0; color = '0;
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    resetn = 1'b1;
    @(negedge clock);
    check_all_zero("after_reset");

    run_rect(10, 5, 3, 2, 1'b0, 5, 0, 1'b0);   // filled 3x2
    run_rect(0, 0, 4, 4, 1'b1, 2, 0, 1'b0);    // outline 4x4
    run_rect(20, 30, 2, 2, 1'b0, 7, 2, 1'b0);  // back-pressure 1,0,0,1
    run_rect(254, 3, 4, 1, 1'b0, 1, 0, 1'b0);  // x wrap
    run_rect(9, 9, 0, 7, 1'b0, 3, 0, 1'b0);    // zero width
    run_rect(9, 9, 5, 0, 1'b1, 3, 0, 1'b1);    // zero height
    run_rect(40, 126, 1, 5, 1'b1, 6, 0, 1'b0); // outline, width 1, y wrap
    run_rect(40, 50, 5, 1, 1'b1, 4, 1, 1'b0);  // outline, height 1
    run_rect(1, 2, 2, 4, 1'b1, 1, 1, 1'b1);    // outline, width 2
    run_rect(3, 4, 255, 3, 1'b1, 5, 1, 1'b0);  // largest width
    for (int i = 0; i < 6; i++)
      run_rect($urandom_range(0, 255), $urandom_range(0, 127),
               $urandom_range(1, 9), $urandom_range(1, 9),
               1'($urandom), $urandom_range(0, 7), $urandom_range(0, 2), 1'b1);

    // Reset after the 3rd pixel of a 5x5: abort immediately, no done.
    @(negedge clock);
    origin_x = 8'd100; origin_y = 7'd20; width = 8'd5; height = 8'd5;
    outline = 1'b0; color = 3'd6; start = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("pre_reset_x", 32'(out_x), 32'd103);
    resetn = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clock);
    check_all_zero("held_reset");
    resetn = 1'b1;
    @(negedge clock);
    check_all_zero("post_abort");
    run_rect(100, 20, 5, 5, 1'b0, 6, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_renderer.md
# rect_renderer

Clocked, parametrised rectangle rasteriser that generalises the square renderer. It accepts independent width and height, a filled or outline mode, and a colour. It emits one pixel coordinate per accepted transfer over a valid/ready stream, in raster order. It sits between the scene/command sequencer and the framebuffer write port; back-pressure from the write port stalls generation without losing pixels.

## Interface
Parameters:
- X_WIDTH, 8, bits of screen x coordinate
- Y_WIDTH, 7, bits of screen y coordinate
- SIZE_WIDTH, 8, bits of rectangle width/height
- COLOR_WIDTH, 3, bits of pixel colour

Ports:
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request new rectangle; sampled only in IDLE
- origin_x  in  X_WIDTH  top-left x
- origin_y  in  Y_WIDTH  top-left y
- width  in  SIZE_WIDTH  pixels per row
- height  in  SIZE_WIDTH  number of rows
- outline  in  1  0 = filled, 1 = border only
- color  in  COLOR_WIDTH  pixel colour
- out_x  out  X_WIDTH  current pixel x
- out_y  out  Y_WIDTH  current pixel y
- out_color  out  COLOR_WIDTH  latched colour
- out_valid  out  1  out_x/out_y/out_color hold a pixel
- out_ready  in  1  downstream accepts pixel this cycle
- busy  out  1  high in DRAW and DONE
- done  out  1  one-cycle pulse after the last pixel transfer

## Operation
- States: IDLE, DRAW, DONE.
- IDLE with start=1:
  - Latch origin_x, origin_y, width, height, outline, color.
  - Clear offsets dx=0, dy=0.
  - Go to DRAW. If width==0 or height==0, go to DONE instead; no pixels are emitted.
- start while busy: ignored; latched values are unaffected.
- DRAW:
  - out_valid=1.
  - out_x = (ox+dx) truncated to X_WIDTH; out_y = (oy+dy) truncated to Y_WIDTH. Wrap-around is intentional and there is no clipping.
  - out_color = latched colour.
- Transfer occurs when out_valid && out_ready. On a transfer, advance:
  - If dx==w-1: set dx=0. If dy==h-1, go to DONE; otherwise dy=dy+1.
  - Else, outline mode on an interior row (0<dy<h-1) with dx==0: dx=w-1 (skip the interior).
  - Else: dx=dx+1.
- Outline mode with w<=2 or h<=2 emits every pixel, so the count equals filled mode.
- Pixel count:
  - Filled: w*h.
  - Outline: w*h if w<=2 or h<=2; otherwise 2w+2(h-2).
- Offset counters are SIZE_WIDTH wide. The comparison with w-1 or h-1 uses latched values, so w=2^SIZE_WIDTH-1 is legal.
- DONE: done=1 and out_valid=0 for one cycle, then go to IDLE. busy stays 1 in DONE, so start is not accepted in that cycle.

## Timing
- Reset (resetn=0, asynchronous): state=IDLE; out_x=0, out_y=0, out_color=0, out_valid=0, busy=0, done=0; latched registers cleared.
- Reset mid-DRAW aborts immediately: no done pulse, and the in-flight pixel is dropped.
- Latency: start sampled at edge N gives out_valid=1 and the first pixel at ox,oy after edge N.
- Handshake:
  - With out_valid=1 and out_ready=0, out_x, out_y and out_color stay stable.
  - out_valid never drops before a transfer.
  - out_valid does not depend combinationally on out_ready.
- Throughput: one pixel per cycle while out_ready=1.
- End of frame: the last transfer at edge M gives done=1 for the cycle after M, then busy=0 after edge M+1.
- Zero-size start at edge N: done=1 after edge N, with no out_valid in between.
- Back-to-back: the earliest next start is the first cycle with busy=0.

## Test plan
- Filled 3x2 at (10,5), colour 5, out_ready=1:
  - Pixels (10,5)(11,5)(12,5)(10,6)(11,6)(12,6) on consecutive cycles, out_color=5.
  - done pulses one cycle after (12,6).
- Outline 4x4 at (0,0): 12 pixels in order (0..3,0), (0,1)(3,1), (0,2)(3,2), (0..3,3); interior never emitted.
- Back-pressure, filled 2x2 with out_ready toggling 1,0,0,1,...: every pixel is held stable while stalled, each is emitted exactly once, and done comes after the 4th transfer.
- Wrap: origin_x=254, width=4, height=1 (X_WIDTH=8): out_x sequence 254, 255, 0, 1.
- Zero size, width=0, height=7: no out_valid, and done asserts the cycle after start. Edge sizes width=1/height=1 in outline mode: all pixels emitted.
- Reset after the 3rd pixel of a 5x5: all outputs 0 at once with no done. A fresh start then begins at origin, and start pulses during DRAW/DONE are ignored.
